// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median window front end.
package median_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam int WIN_SIZE = 9;
  localparam int IDX_W    = 4;

endpackage

// File: rtl/median_window_line_buffer.sv
// Single-row pixel store: combinational read, write on the rising edge.
module line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // write port; contents are always overwritten before they are read back
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/median_window.sv
// Raster-to-3x3 window serializer feeding a median stage, one window per accepted interior pixel.
// Optional sticky ERR output for pixels offered while busy: define MEDIAN_WINDOW_ERR_EN.
module median_window
  import median_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LINE   = 64,
  parameter int HEIGHT = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  output logic             RDY,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  input  logic             MDONE
`ifdef MEDIAN_WINDOW_ERR_EN
  ,
  output logic             ERR
`endif
);

  localparam int CW = $clog2(LINE);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(LINE - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST = RW'(2);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(WIN_SIZE);

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  win_q [WIN_SIZE];
  logic [WIDTH-1:0]  win_d [WIN_SIZE];
  logic [WIDTH-1:0]  do_q, do_d;
  logic              dso_q, dso_d;
  logic              rdy_q, rdy_d;
  logic              acc_s;
  logic [WIDTH-1:0]  up1_s, up2_s;

  assign acc_s = DSI & rdy_q;

  line_buffer #(.WIDTH(WIDTH), .DEPTH(LINE)) u_row1 (
    .clk(CLK), .we(acc_s), .addr(col_q), .wdata(DI), .rdata(up1_s)
  );

  line_buffer #(.WIDTH(WIDTH), .DEPTH(LINE)) u_row2 (
    .clk(CLK), .we(acc_s), .addr(col_q), .wdata(up1_s), .rdata(up2_s)
  );

  // window is kept in emission order: index = column*3 + row, column 0 oldest
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    idx_d   = idx_q;
    win_d   = win_q;
    do_d    = '0;
    dso_d   = 1'b0;
    rdy_d   = 1'b0;

    if (acc_s) begin
      for (int k = 0; k < WIN_SIZE - 3; k++) begin
        win_d[k] = win_q[k + 3];
      end
      win_d[6] = up2_s;
      win_d[7] = up1_s;
      win_d[8] = DI;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      win_d = win_q;
    end

    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (acc_s && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST)) begin
          state_d = EMIT;
          do_d    = win_d[0];
          dso_d   = 1'b1;
          idx_d   = IDX_W'(1);
          rdy_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (idx_q < IDX_END) begin
          do_d  = win_q[idx_q];
          dso_d = 1'b1;
          idx_d = idx_q + IDX_W'(1);
        end else begin
          state_d = WAIT;
          idx_d   = '0;
        end
      end
      WAIT: begin
        if (MDONE) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // state, counters, window and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      do_q    <= '0;
      dso_q   <= 1'b0;
      rdy_q   <= 1'b1;
      for (int k = 0; k < WIN_SIZE; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      do_q    <= do_d;
      dso_q   <= dso_d;
      rdy_q   <= rdy_d;
      for (int k = 0; k < WIN_SIZE; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

  assign RDY = rdy_q;
  assign DO  = do_q;
  assign DSO = dso_q;

`ifdef MEDIAN_WINDOW_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (DSI & ~rdy_q);
  end

  // sticky record of pixels offered while busy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`endif

endmodule

// File: tb/tb_median_window.sv
// Directed bench for median_window on a 4x4 frame with a delayed MDONE responder.
module tb_median_window;

  localparam int WIDTH  = 8;
  localparam int LINE   = 4;
  localparam int HEIGHT = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] DI;
  logic             DSI;
  logic             RDY;
  logic [WIDTH-1:0] DO;
  logic             DSO;
  logic             MDONE;
`ifdef MEDIAN_WINDOW_ERR_EN
  logic             ERR;
`endif

  int checks   = 0;
  int failures = 0;
  int nburst;
  int got   [0:3][0:8];
  int exp_b [0:3][0:8] = '{
    '{0, 4,  8, 1, 5,  9, 2,  6, 10},
    '{1, 5,  9, 2, 6, 10, 3,  7, 11},
    '{4, 8, 12, 5, 9, 13, 6, 10, 14},
    '{5, 9, 13, 6, 10, 14, 7, 11, 15}
  };

  always #5 CLK = ~CLK;

  median_window #(.WIDTH(WIDTH), .LINE(LINE), .HEIGHT(HEIGHT)) dut (
    .CLK(CLK), .RST(RST), .DI(DI), .DSI(DSI), .RDY(RDY),
    .DO(DO), .DSO(DSO), .MDONE(MDONE)
`ifdef MEDIAN_WINDOW_ERR_EN
    , .ERR(ERR)
`endif
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Streams pixels 0..15 with DSI held high; captures bursts and answers with MDONE.
  task automatic stream_frame(input bit hold_first, input bit mdone_in_emit, input bit abort_first);
    int p = 0;
    int cyc = 0;
    int wait_len;
    bit acc;
    bit bad;
    nburst = 0;
    DI  = 8'd0;
    DSI = 1'b1;
    while (p < 16 && cyc < 3000) begin
      acc = RDY;
      @(negedge CLK);
      cyc++;
      MDONE = 1'b0;
      if (acc) p++;
      if (p < 16) DI = 8'(p);
      else DSI = 1'b0;
      if (DSO) begin
        if (nburst < 4) got[nburst][0] = DO;
        for (int k = 1; k < 9; k++) begin
          @(negedge CLK);
          cyc++;
          if (abort_first && nburst == 0 && k == 4) begin
            RST = 1'b1;
            #1;
            check_eq("abort_dso", DSO, 0);
            check_eq("abort_do", DO, 0);
            @(negedge CLK);
            RST   = 1'b0;
            DSI   = 1'b0;
            MDONE = 1'b0;
            return;
          end
          if (mdone_in_emit && nburst == 1) MDONE = (k == 3);
          if (nburst < 4) got[nburst][k] = DSO ? int'(DO) : 999;
        end
        MDONE = 1'b0;
        @(negedge CLK);
        cyc++;
        check_eq($sformatf("burst%0d_end_dso", nburst), DSO, 0);
        bad = 1'b0;
        wait_len = (hold_first && nburst == 0) ? 100 : 39;
        for (int w = 0; w < wait_len; w++) begin
          if (RDY || DSO || DO != 8'd0) bad = 1'b1;
          @(negedge CLK);
          cyc++;
        end
        check_eq($sformatf("burst%0d_wait_hold", nburst), bad, 0);
        MDONE = 1'b1;
        @(negedge CLK);
        cyc++;
        MDONE = 1'b0;
        check_eq($sformatf("burst%0d_release_rdy", nburst), RDY, 1);
        nburst++;
      end
    end
    DSI = 1'b0;
    check_eq("stream_done", p, 16);
  endtask

  initial begin
    RST   = 1'b1;
    DSI   = 1'b0;
    DI    = 8'd0;
    MDONE = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_eq("reset_rdy", RDY, 1);
    check_eq("reset_dso", DSO, 0);
    check_eq("reset_do", DO, 0);
`ifdef MEDIAN_WINDOW_ERR_EN
    check_eq("reset_err", ERR, 0);
`endif

    // frame A: long MDONE hold on burst 0, stray MDONE inside burst 1
    stream_frame(1'b1, 1'b1, 1'b0);
    check_eq("frameA_bursts", nburst, 4);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 9; k++) begin
        check_eq($sformatf("frameA_b%0d_px%0d", b, k), got[b][k], exp_b[b][k]);
      end
    end
`ifdef MEDIAN_WINDOW_ERR_EN
    check_eq("err_sticky", ERR, 1);
`endif

    // frame B: reset lands in the fifth cycle of the first burst
    stream_frame(1'b0, 1'b0, 1'b1);
    check_eq("abort_bursts", nburst, 0);
    check_eq("post_abort_rdy", RDY, 1);
    check_eq("post_abort_dso", DSO, 0);
`ifdef MEDIAN_WINDOW_ERR_EN
    check_eq("post_abort_err", ERR, 0);
`endif

    // frame C: clean restream after the abort
    stream_frame(1'b0, 1'b0, 1'b0);
    check_eq("frameC_bursts", nburst, 4);
    for (int k = 0; k < 9; k++) begin
      check_eq($sformatf("frameC_b0_px%0d", k), got[0][k], exp_b[0][k]);
      check_eq($sformatf("frameC_b3_px%0d", k), got[3][k], exp_b[3][k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
